// File: rtl/pixel_in_buffer.sv
// Pixel input buffer: 192-byte 8x8 RGB tile, filled by 4-lane beats, drained by RGB reads.
// Define IB_OOR_FLAG_EN to add the sticky out-of-range flag O_IB_OOR.
module pixel_in_buffer (
   input  logic        I_IB_HCLK,
   input  logic        I_IB_RESET,
   input  logic        I_IB_WR_EN,
   input  logic [7:0]  I_IB_ADDR0,
   input  logic [7:0]  I_IB_ADDR1,
   input  logic [7:0]  I_IB_ADDR2,
   input  logic [7:0]  I_IB_ADDR3,
   input  logic [31:0] I_IB_WDATA,
   input  logic        I_IB_RD_EN,
   input  logic [7:0]  I_IB_ADDRR,
   input  logic [7:0]  I_IB_ADDRG,
   input  logic [7:0]  I_IB_ADDRB,
   input  logic        I_IB_CLEAR,
   output logic [7:0]  O_IB_DATAR,
   output logic [7:0]  O_IB_DATAG,
   output logic [7:0]  O_IB_DATAB,
   output logic        O_IB_RVALID,
   output logic        O_IB_EMPTY,
   output logic        O_IB_FULL,
   output logic [5:0]  O_IB_WR_COUNT,
   output logic        O_IB_OVERFLOW
`ifdef IB_OOR_FLAG_EN
   ,output logic       O_IB_OOR
`endif
);

   localparam int unsigned DEPTH = 192;
   localparam logic [7:0] LIMIT = 8'hC0;
   localparam logic [5:0] LAST_BEAT = 6'd47;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_FILL,
      ST_FULL
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic        rvalid_q, rvalid_d;
   logic [7:0]  dr_q, dr_d;
   logic [7:0]  dg_q, dg_d;
   logic [7:0]  db_q, db_d;
   logic [7:0]  mem_q [DEPTH];
   logic [7:0]  mem_d [DEPTH];
   logic [7:0]  lane_addr [4];
   logic        wr_acc;
   logic        rd_acc;
   logic        wr_oor;
   logic        rd_oor;

   always_comb begin
      lane_addr[0] = I_IB_ADDR0;
      lane_addr[1] = I_IB_ADDR1;
      lane_addr[2] = I_IB_ADDR2;
      lane_addr[3] = I_IB_ADDR3;
   end

   // Clear outranks both strobes in the same cycle.
   assign wr_acc = I_IB_WR_EN && !I_IB_CLEAR && (state_q != ST_FULL);
   assign rd_acc = I_IB_RD_EN && !I_IB_CLEAR && (state_q == ST_FULL);

   assign wr_oor = (I_IB_ADDR0 >= LIMIT) || (I_IB_ADDR1 >= LIMIT)
                || (I_IB_ADDR2 >= LIMIT) || (I_IB_ADDR3 >= LIMIT);
   assign rd_oor = (I_IB_ADDRR >= LIMIT) || (I_IB_ADDRG >= LIMIT)
                || (I_IB_ADDRB >= LIMIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (I_IB_CLEAR) begin
         state_d = ST_EMPTY;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_EMPTY,
            ST_FILL: begin
               if (wr_acc) begin
                  cnt_d   = cnt_q + 6'd1;
                  state_d = (cnt_q == LAST_BEAT) ? ST_FULL : ST_FILL;
               end
            end
            ST_FULL: begin
               if (I_IB_WR_EN) ovf_d = 1'b1;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Ascending lane order lets the highest lane win on duplicate addresses.
   always_comb begin
      mem_d = mem_q;
      if (wr_acc) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_addr[i] < LIMIT) begin
               mem_d[lane_addr[i]] = I_IB_WDATA[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      rvalid_d = rd_acc;
      dr_d     = dr_q;
      dg_d     = dg_q;
      db_d     = db_q;
      if (rd_acc) begin
         dr_d = (I_IB_ADDRR < LIMIT) ? mem_q[I_IB_ADDRR] : 8'h00;
         dg_d = (I_IB_ADDRG < LIMIT) ? mem_q[I_IB_ADDRG] : 8'h00;
         db_d = (I_IB_ADDRB < LIMIT) ? mem_q[I_IB_ADDRB] : 8'h00;
      end
   end

   always_ff @(posedge I_IB_HCLK) begin
      if (I_IB_RESET) begin
         state_q  <= ST_EMPTY;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         dr_q     <= '0;
         dg_q     <= '0;
         db_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         rvalid_q <= rvalid_d;
         dr_q     <= dr_d;
         dg_q     <= dg_d;
         db_q     <= db_d;
      end
   end

   // Tile storage carries no reset; contents are refilled before use.
   always_ff @(posedge I_IB_HCLK) begin
      mem_q <= mem_d;
   end

`ifdef IB_OOR_FLAG_EN
   logic oor_q, oor_d;

   always_comb begin
      oor_d = oor_q;
      if (I_IB_CLEAR) begin
         oor_d = 1'b0;
      end else if ((wr_acc && wr_oor) || (rd_acc && rd_oor)) begin
         oor_d = 1'b1;
      end
   end

   always_ff @(posedge I_IB_HCLK) begin
      if (I_IB_RESET) oor_q <= 1'b0;
      else            oor_q <= oor_d;
   end

   assign O_IB_OOR = oor_q;
`else
   logic unused_oor;
   assign unused_oor = wr_oor ^ rd_oor;
`endif

   assign O_IB_DATAR    = dr_q;
   assign O_IB_DATAG    = dg_q;
   assign O_IB_DATAB    = db_q;
   assign O_IB_RVALID   = rvalid_q;
   assign O_IB_EMPTY    = (state_q == ST_EMPTY);
   assign O_IB_FULL     = (state_q == ST_FULL);
   assign O_IB_WR_COUNT = cnt_q;
   assign O_IB_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_pixel_in_buffer.sv
// Bench for pixel_in_buffer: tile-level model compared every cycle, plus literal checks.
// Define IB_OOR_FLAG_EN to also exercise O_IB_OOR.
module tb_pixel_in_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  a0 = '0, a1 = '0, a2 = '0, a3 = '0;
   logic [31:0] wdata = '0;
   logic        rd_en = 1'b0;
   logic [7:0]  ar = '0, ag = '0, ab = '0;
   logic        clr = 1'b0;
   logic [7:0]  dr, dg, db;
   logic        rvalid, empty, full, ovf;
   logic [5:0]  wcnt;
   logic        oor;

   pixel_in_buffer dut (
      .I_IB_HCLK     (clk),
      .I_IB_RESET    (rst),
      .I_IB_WR_EN    (wr_en),
      .I_IB_ADDR0    (a0),
      .I_IB_ADDR1    (a1),
      .I_IB_ADDR2    (a2),
      .I_IB_ADDR3    (a3),
      .I_IB_WDATA    (wdata),
      .I_IB_RD_EN    (rd_en),
      .I_IB_ADDRR    (ar),
      .I_IB_ADDRG    (ag),
      .I_IB_ADDRB    (ab),
      .I_IB_CLEAR    (clr),
      .O_IB_DATAR    (dr),
      .O_IB_DATAG    (dg),
      .O_IB_DATAB    (db),
      .O_IB_RVALID   (rvalid),
      .O_IB_EMPTY    (empty),
      .O_IB_FULL     (full),
      .O_IB_WR_COUNT (wcnt),
      .O_IB_OVERFLOW (ovf)
`ifdef IB_OOR_FLAG_EN
      ,.O_IB_OOR     (oor)
`endif
   );

`ifndef IB_OOR_FLAG_EN
   assign oor = 1'b0;
`endif

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit started = 1'b0;

   // Model: tile bytes with known flags, beat count, sticky flags, read outputs.
   logic [7:0] m [192];
   bit         mk [192];
   int         cnt = 0;
   bit         e_ovf = 0, e_oor = 0, e_rv = 0;
   logic [7:0] e_dr = 0, e_dg = 0, e_db = 0;
   bit         k_dr = 1, k_dg = 1, k_db = 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (started) begin
         chk("empty", 32'(empty), 32'(cnt == 0));
         chk("full", 32'(full), 32'(cnt == 48));
         chk("count", 32'(wcnt), 32'(cnt));
         chk("overflow", 32'(ovf), 32'(e_ovf));
         chk("rvalid", 32'(rvalid), 32'(e_rv));
         if (k_dr) chk("datar", 32'(dr), 32'(e_dr));
         if (k_dg) chk("datag", 32'(dg), 32'(e_dg));
         if (k_db) chk("datab", 32'(db), 32'(e_db));
`ifdef IB_OOR_FLAG_EN
         chk("oor", 32'(oor), 32'(e_oor));
`endif
      end
   end

   task automatic rd_byte(input logic [7:0] a, output logic [7:0] d,
                          output bit k);
      if (a < 8'hC0) begin
         d = m[a];
         k = mk[a];
      end else begin
         d = 8'h00;
         k = 1'b1;
         e_oor = 1'b1;
      end
   endtask

   task automatic model();
      logic [7:0] la [4];
      bit full0;
      la[0] = a0; la[1] = a1; la[2] = a2; la[3] = a3;
      full0 = (cnt == 48);
      if (rst) begin
         cnt = 0; e_ovf = 0; e_oor = 0; e_rv = 0;
         e_dr = 0; e_dg = 0; e_db = 0;
         k_dr = 1; k_dg = 1; k_db = 1;
         for (int i = 0; i < 192; i++) mk[i] = 1'b0;
      end else if (clr) begin
         cnt = 0; e_ovf = 0; e_oor = 0; e_rv = 0;
      end else begin
         e_rv = 0;
         if (rd_en && full0) begin
            e_rv = 1;
            rd_byte(ar, e_dr, k_dr);
            rd_byte(ag, e_dg, k_dg);
            rd_byte(ab, e_db, k_db);
         end
         if (wr_en) begin
            if (full0) begin
               e_ovf = 1;
            end else begin
               for (int i = 0; i < 4; i++) begin
                  if (la[i] < 8'hC0) begin
                     m[la[i]] = wdata[8*i +: 8];
                     mk[la[i]] = 1'b1;
                  end else begin
                     e_oor = 1'b1;
                  end
               end
               cnt++;
            end
         end
      end
   endtask

   task automatic tick();
      model();
      @(posedge clk);
      #2;
      rst = 0; wr_en = 0; rd_en = 0; clr = 0;
   endtask

   task automatic wr_beat(input logic [7:0] x0, input logic [7:0] x1,
                          input logic [7:0] x2, input logic [7:0] x3,
                          input logic [31:0] d);
      wr_en = 1; a0 = x0; a1 = x1; a2 = x2; a3 = x3; wdata = d;
      tick();
   endtask

   task automatic rd_px(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
      rd_en = 1; ar = r; ag = g; ab = b;
      tick();
   endtask

   task automatic seq_beats(input int first, input int n);
      logic [7:0] a;
      for (int k = first; k < first + n; k++) begin
         a = 8'(4 * k);
         wr_beat(a, a + 8'd1, a + 8'd2, a + 8'd3,
                 {a + 8'd3, a + 8'd2, a + 8'd1, a});
      end
   endtask

   initial begin
      started = 1'b1;
      rst = 1;
      tick();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(wcnt), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_data", 32'({dr, dg, db}), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);

      seq_beats(0, 47);
      chk("fill47_full", 32'(full), 32'd0);
      chk("fill47_count", 32'(wcnt), 32'd47);
      seq_beats(47, 1);
      chk("fill48_full", 32'(full), 32'd1);
      chk("fill48_count", 32'(wcnt), 32'd48);
      rd_px(8'h15, 8'h16, 8'h17);
      chk("rd_rvalid", 32'(rvalid), 32'd1);
      chk("rd_rgb", 32'({dr, dg, db}), 32'h151617);
      rd_px(8'hBF, 8'h00, 8'h80);
      chk("rd_edge", 32'({dr, dg, db}), 32'hBF0080);

      wr_beat(8'h00, 8'h01, 8'h02, 8'h03, 32'hFFFF_FFFF);
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("ovf_count", 32'(wcnt), 32'd48);
      rd_px(8'h00, 8'h01, 8'h03);
      chk("ovf_rd", 32'({dr, dg, db}), 32'h000103);
      clr = 1; rd_en = 1; ar = 8'h20;
      tick();
      chk("clr_empty", 32'(empty), 32'd1);
      chk("clr_ovf", 32'(ovf), 32'd0);
      chk("clr_count", 32'(wcnt), 32'd0);
      chk("clr_rvalid", 32'(rvalid), 32'd0);

      seq_beats(0, 10);
      chk("ten_count", 32'(wcnt), 32'd10);
      chk("ten_empty", 32'(empty), 32'd0);
      clr = 1;
      wr_beat(8'h30, 8'h31, 8'h32, 8'h33, 32'h1234_5678);
      chk("clrwr_empty", 32'(empty), 32'd1);
      chk("clrwr_count", 32'(wcnt), 32'd0);
      rd_px(8'h10, 8'h11, 8'h12);
      chk("rd_empty_rvalid", 32'(rvalid), 32'd0);
      chk("rd_empty_hold", 32'({dr, dg, db}), 32'h000103);

      wr_beat(8'h10, 8'h11, 8'hC4, 8'h10, 32'hDD00_00AA);
      chk("dup_count", 32'(wcnt), 32'd1);
`ifdef IB_OOR_FLAG_EN
      chk("oor_wr", 32'(oor), 32'd1);
`endif
      for (int k = 0; k < 47; k++) begin
         logic [7:0] a;
         a = 8'(8'h20 + ((4 * k) % 160));
         wr_beat(a, a + 8'd1, a + 8'd2, a + 8'd3, {4{a ^ 8'h5A}});
      end
      chk("dup_full", 32'(full), 32'd1);
      rd_px(8'h10, 8'h11, 8'hC0);
      chk("dup_rd", 32'({dr, dg, db}), 32'hDD0000);
`ifdef IB_OOR_FLAG_EN
      chk("oor_hold", 32'(oor), 32'd1);
`endif
      clr = 1;
      tick();
`ifdef IB_OOR_FLAG_EN
      chk("oor_clr", 32'(oor), 32'd0);
`endif

      seq_beats(0, 20);
      rst = 1; wr_en = 1;
      tick();
      chk("rst2_empty", 32'(empty), 32'd1);
      chk("rst2_count", 32'(wcnt), 32'd0);
      chk("rst2_rvalid", 32'(rvalid), 32'd0);
      seq_beats(0, 48);
      chk("refill_full", 32'(full), 32'd1);
      rd_px(8'h15, 8'h16, 8'h17);
      chk("refill_rd", 32'({dr, dg, db}), 32'h151617);
      rd_px(8'h40, 8'h41, 8'h42);
      tick();
      chk("idle_rvalid", 32'(rvalid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pixel_in_buffer.md
PIXEL_IN_BUFFER -- requirements
Module: pixel_in_buffer

Interface
REQ-001 I_IB_HCLK  input  1  sole clock; all state updates on rising edge.
REQ-002 I_IB_RESET  input  1  reset, synchronous, active-high.
REQ-003 I_IB_WR_EN  input  1  write strobe: one 32-bit AHB beat (4 bytes) this cycle.
REQ-004 I_IB_ADDR0 / I_IB_ADDR1 / I_IB_ADDR2 / I_IB_ADDR3  input  8 each  byte addresses for write lanes 0..3.
REQ-005 I_IB_WDATA  input  32  write data; lane0=[7:0], lane1=[15:8], lane2=[23:16], lane3=[31:24].
REQ-006 I_IB_RD_EN  input  1  read strobe: one RGB pixel fetch this cycle.
REQ-007 I_IB_ADDRR / I_IB_ADDRG / I_IB_ADDRB  input  8 each  byte addresses for R, G, B reads.
REQ-008 I_IB_CLEAR  input  1  release buffer after drain or abort.
REQ-009 O_IB_DATAR / O_IB_DATAG / O_IB_DATAB  output  8 each  registered read data.
REQ-010 O_IB_RVALID  output  1  read data valid, one cycle per accepted read.
REQ-011 O_IB_EMPTY / O_IB_FULL  output  1 each  buffer state flags.
REQ-012 O_IB_WR_COUNT  output  6  accepted write beats since last clear (0..48).
REQ-013 O_IB_OVERFLOW  output  1  sticky: write attempted while FULL.
REQ-014 O_IB_OOR  output  1  sticky out-of-range address flag; present only with IB_OOR_FLAG_EN.

Function
REQ-015 Storage SHALL be 192 bytes (one 8x8 RGB tile), addresses 0x00..0xBF; addresses >= 0xC0 are out of range.
REQ-016 FSM states SHALL be EMPTY, FILL, FULL; O_IB_EMPTY=1 only in EMPTY, O_IB_FULL=1 only in FULL.
REQ-017 EMPTY -> FILL on first accepted write; FILL -> FULL on the write that brings O_IB_WR_COUNT to 48; FULL -> EMPTY on I_IB_CLEAR; FILL -> EMPTY on I_IB_CLEAR (abort).
REQ-018 Writes SHALL be accepted only in EMPTY or FILL; each accepted write stores all four lanes in that cycle and increments O_IB_WR_COUNT by 1.
REQ-019 Write while FULL SHALL be ignored (memory and count unchanged) and set O_IB_OVERFLOW.
REQ-020 Duplicate addresses across lanes in one beat: highest-numbered lane SHALL win.
REQ-021 Out-of-range write lane: that byte SHALL be dropped; other lanes written; the beat still counts.
REQ-022 Reads SHALL be accepted only in FULL; data registered on the accepting edge, O_IB_RVALID=1 the following cycle (latency 1).
REQ-023 Read while not FULL: O_IB_RVALID=0 next cycle, data outputs hold.
REQ-024 Out-of-range read address: corresponding data output SHALL be 0x00.
REQ-025 Simultaneous I_IB_CLEAR with I_IB_WR_EN or I_IB_RD_EN: clear SHALL win; write and read are dropped, O_IB_RVALID=0 next cycle, O_IB_OVERFLOW not set.
REQ-026 I_IB_CLEAR SHALL zero O_IB_WR_COUNT and clear O_IB_OVERFLOW and O_IB_OOR; memory contents are not cleared.

Reset
REQ-027 On I_IB_RESET: state=EMPTY, O_IB_EMPTY=1, O_IB_FULL=0, O_IB_WR_COUNT=0, O_IB_RVALID=0, data outputs=0x00, O_IB_OVERFLOW=0, O_IB_OOR=0.
REQ-028 Reset mid-fill or mid-drain SHALL abort immediately; memory contents are undefined afterwards and are not read before the next fill.

Configuration
REQ-029 Macro IB_OOR_FLAG_EN defined: O_IB_OOR is present and set by any accepted write lane or accepted read with address >= 0xC0.
REQ-030 Macro IB_OOR_FLAG_EN undefined: O_IB_OOR port and logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset, then 48 writes with ADDR0..3 = 4k..4k+3 and WDATA bytes = address -> FULL=1 after 48th beat, WR_COUNT=48; read R/G/B=0x15/0x16/0x17 -> next cycle RVALID=1, data 0x15/0x16/0x17.
REQ-032 While FULL, write WDATA=0xFFFFFFFF to 0x00..0x03 -> OVERFLOW=1, subsequent read of 0x00 returns 0x00; then CLEAR -> EMPTY=1, OVERFLOW=0, WR_COUNT=0.
REQ-033 10 writes, then CLEAR asserted together with WR_EN -> EMPTY=1, WR_COUNT=0 next cycle; RD_EN in EMPTY -> RVALID stays 0.
REQ-034 Beat with ADDR0=ADDR3=0x10, WDATA=0xDD0000AA; fill to FULL; read 0x10 -> 0xDD.
REQ-035 With IB_OOR_FLAG_EN: write lane address 0xC4, fill, read ADDRB=0xC0 -> that byte not stored, DATAB=0x00, OOR=1 until CLEAR.
REQ-036 Assert I_IB_RESET after 20 writes -> next cycle EMPTY=1, WR_COUNT=0, RVALID=0; a fresh 48-beat fill reaches FULL normally.
